// File: rtl/traffic_sensor_conditioner_if.sv
// Bus between the raw loop-detector front-end and the traffic light controller.
//   inputs to the conditioner : sa_raw, sb_raw (asynchronous sensors),
//                               cnt_clr, fault_clr (synchronous clears)
//   outputs of the conditioner: sa, sb (presence), arrive_a/b (arrival pulses),
//                               count_a/b (saturating arrival counts),
//                               fault_a/b (sticky stuck-sensor flags)
// master = side that drives the sensors/clears, slave = the conditioner.
interface traffic_sensor_conditioner_if;
  logic       sa_raw;
  logic       sb_raw;
  logic       cnt_clr;
  logic       fault_clr;
  logic       sa;
  logic       sb;
  logic       arrive_a;
  logic       arrive_b;
  logic [7:0] count_a;
  logic [7:0] count_b;
  logic       fault_a;
  logic       fault_b;

  modport master (
    output sa_raw, sb_raw, cnt_clr, fault_clr,
    input  sa, sb, arrive_a, arrive_b, count_a, count_b, fault_a, fault_b
  );

  modport slave (
    input  sa_raw, sb_raw, cnt_clr, fault_clr,
    output sa, sb, arrive_a, arrive_b, count_a, count_b, fault_a, fault_b
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the Street A / Street B loop-detector inputs for the traffic
// light controller: 2-flop synchronizer, debounce, hold stretch, saturating
// arrival counter and sticky stuck-sensor monitor per street.
// Ports:
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : slave side of traffic_sensor_conditioner_if (sensors, clears,
//            presence, arrival pulses/counts, fault flags)
// Channel 0 is Street A, channel 1 is Street B; the channels never interact.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 20_000_000,
  parameter int STUCK_CYCLES    = 200_000_000,
  parameter int CNT_W           = 28
) (
  input logic                          clk,
  input logic                          resetn,
  traffic_sensor_conditioner_if.slave  bus
);
  localparam int NUM_CH = 2;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STK_LAST  = CNT_W'(STUCK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, QUALIFY, PRESENT, HOLD} state_e;

  logic [NUM_CH-1:0]      raw, pres, arrive, fault;
  logic [NUM_CH-1:0][7:0] count;

  assign raw = {bus.sb_raw, bus.sa_raw};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic           s1_q, sync_q;
    state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, stk_q, stk_d;
    logic           fault_q, fault_d, pres_q, pres_d, arrive_q, arrive_d;
    logic [7:0]     count_q, count_d;

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      arrive_d = 1'b0;
      case (state_q)
        IDLE: if (sync_q) begin
          state_d = QUALIFY;
          cnt_d   = '0;
        end
        QUALIFY: begin
          if (!sync_q) state_d = IDLE;
          else if (cnt_q == DEB_LAST) begin
            state_d  = PRESENT;
            arrive_d = 1'b1;
          end else cnt_d = cnt_q + 1'b1;
        end
        PRESENT: if (!sync_q) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
        HOLD: begin
          // Re-press inside the hold window is the same vehicle: no pulse.
          if (sync_q) state_d = PRESENT;
          else if (cnt_q == HOLD_LAST) state_d = IDLE;
          else cnt_d = cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase

      // Stuck monitor: counts consecutive PRESENT cycles; it parks at the
      // last value once the threshold is hit so it can never wrap.
      stk_d   = stk_q;
      fault_d = fault_q;
      if (state_q != PRESENT) stk_d = '0;
      else begin
        if (stk_q != STK_LAST) stk_d = stk_q + 1'b1;
        if (stk_q == STK_LAST) fault_d = 1'b1;
      end
      if (bus.fault_clr) begin
        fault_d = 1'b0;
        stk_d   = '0;
      end

      count_d = count_q;
      if (bus.cnt_clr) count_d = '0;
      else if (arrive_d && count_q != 8'hFF) count_d = count_q + 8'd1;

      // A faulty sensor forces presence so the street is never starved.
      pres_d = (state_d == PRESENT) || (state_d == HOLD) || fault_d;
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        s1_q     <= 1'b0;
        sync_q   <= 1'b0;
        state_q  <= IDLE;
        cnt_q    <= '0;
        stk_q    <= '0;
        fault_q  <= 1'b0;
        pres_q   <= 1'b0;
        arrive_q <= 1'b0;
        count_q  <= '0;
      end else begin
        s1_q     <= raw[g];
        sync_q   <= s1_q;
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        stk_q    <= stk_d;
        fault_q  <= fault_d;
        pres_q   <= pres_d;
        arrive_q <= arrive_d;
        count_q  <= count_d;
      end
    end

    assign pres[g]   = pres_q;
    assign arrive[g] = arrive_q;
    assign fault[g]  = fault_q;
    assign count[g]  = count_q;
  end

  assign bus.sa       = pres[0];
  assign bus.sb       = pres[1];
  assign bus.arrive_a = arrive[0];
  assign bus.arrive_b = arrive[1];
  assign bus.count_a  = count[0];
  assign bus.count_b  = count[1];
  assign bus.fault_a  = fault[0];
  assign bus.fault_b  = fault[1];
endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
Upstream front-end for the traffic light controller. It takes the raw loop-detector inputs for Street A and Street B and produces clean, debounced, hold-stretched presence signals `sa`/`sb` for the controller's `sa`/`sb` inputs. Each channel also has a saturating arrival counter and a stuck-sensor fault monitor. While a channel is in fault, its presence output is forced high (fail-safe: the street is never starved).

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive synchronized-high cycles required to declare presence; must be >= 1.
- HOLD_CYCLES, 20_000_000: cycles presence is stretched after the sensor drops; must be >= 1.
- STUCK_CYCLES, 200_000_000: continuous PRESENT cycles after which the channel is flagged faulty; must be >= 1.
- CNT_W, 28: width of the debounce, hold and stuck counters; must hold every cycle parameter.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- sa_raw  in  1  raw asynchronous sensor, Street A
- sb_raw  in  1  raw asynchronous sensor, Street B
- cnt_clr  in  1  synchronous clear of both arrival counters
- fault_clr  in  1  synchronous clear of both fault flags
- sa  out  1  conditioned presence, Street A (drives controller sa)
- sb  out  1  conditioned presence, Street B (drives controller sb)
- arrive_a  out  1  one-cycle pulse on a new Street A arrival
- arrive_b  out  1  one-cycle pulse on a new Street B arrival
- count_a  out  8  saturating arrival count, Street A
- count_b  out  8  saturating arrival count, Street B
- fault_a  out  1  sticky stuck-sensor flag, Street A
- fault_b  out  1  sticky stuck-sensor flag, Street B

Behaviour:
- Reset (resetn low at a clock edge):
  - Both synchronizer flops cleared and both channels placed in IDLE with counters at 0.
  - Outputs: sa = sb = 0, arrive_a = arrive_b = 0, count_a = count_b = 0, fault_a = fault_b = 0.
  - Reset mid-operation discards any partial debounce or hold with no pulse.
- Synchronization: raw input passes through 2 flops; `sync` denotes the second flop.
- Two identical, independent channels. Each has a state machine with states IDLE, QUALIFY, PRESENT and HOLD, plus a counter `cnt`:
  - IDLE: if sync = 1, go to QUALIFY with cnt = 0.
  - QUALIFY: if sync = 0, go to IDLE (glitch rejected, no pulse). Else if cnt = DEBOUNCE_CYCLES-1, go to PRESENT and pulse arrive_x for 1 cycle. Else cnt++.
  - PRESENT: if sync = 0, go to HOLD with cnt = 0.
  - HOLD: if sync = 1, go to PRESENT (no new arrival pulse). Else if cnt = HOLD_CYCLES-1, go to IDLE. Else cnt++.
- Outputs are registered Moore outputs.
  - Presence = (state is PRESENT or HOLD) or fault_x.
  - arrive_x is high in exactly the cycle after the QUALIFY-to-PRESENT edge.
- Latency:
  - Raw rise sampled at edge N: sa is high after edge N+2+DEBOUNCE_CYCLES.
  - Raw fall sampled at edge N (from PRESENT): sa is low after edge N+2+HOLD_CYCLES.
- Arrival counters:
  - +1 on each arrival, saturating at 255 (no wrap).
  - cnt_clr sets the count to 0 and wins over a same-cycle increment; that arrival is not counted, but its pulse is still issued.
- Stuck monitor:
  - A separate counter counts consecutive cycles in PRESENT and resets on leaving PRESENT.
  - On reaching STUCK_CYCLES, fault_x is set and stays set.
  - fault_clr clears the flag and the stuck counter. If the fault condition persists, the flag re-asserts after another full STUCK_CYCLES.
  - fault_x does not alter the channel state machine.
- Simultaneous events:
  - Channels never interact.
  - fault_clr and a stuck threshold reached in the same cycle: clear wins.
- Arithmetic: all counters unsigned CNT_W bits, with compares done at full width. Out-of-range parameters are not supported and need no check.

Test Plan:
Parameters for all scenarios: DEBOUNCE=4, HOLD=6, STUCK=20.

1. Clean rise: sa_raw=1 sampled at edge 10 → sa=1 and arrive_a pulses after edge 16; count_a=1; sb stays 0.
2. Glitch: sa_raw high for 3 cycles, then low → sa never rises, no arrive_a, count_a=0. A 3-cycle dropout inside HOLD → sa stays 1 with no second pulse.
3. Release: sa_raw falls, sampled at edge 50 → sa low after edge 58. A re-press afterwards gives count_a=2.
4. Stuck: sb_raw held high → fault_b=1 exactly 20 cycles after PRESENT entry. Drop sb_raw → sb stays 1. Pulse fault_clr → sb low once the hold expires.
5. Counters: 256 arrivals → count_a=255 (saturated). Apply cnt_clr on the same cycle as an arrival → count_a=0 and arrive_a still pulses.
6. Reset mid-QUALIFY and mid-HOLD with resetn=0 for 1 cycle → all outputs 0 on the next cycle and no arrive pulse.
